// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, one op per cycle, and a single-entry registered response
// slot per requester. A slot can be drained and refilled in the same cycle.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0 (execute stage)
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  // requester 1 (address / branch-compare unit)
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  // response slot 0
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  // response slot 1
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  // statistics
  output logic [CNTW-1:0]  op_count
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;

  // 0: requester 0 won last, 1: requester 1 won last
  logic             r_last_grant;
  logic             r_rsp0_valid;
  logic [WIDTH-1:0] r_rsp0_result;
  logic             r_rsp0_zero;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp1_result;
  logic             r_rsp1_zero;
  logic [CNTW-1:0]  r_op_count;

  // Eligibility (slot empty or draining this cycle) and round-robin grant
  always_comb begin
    w_elig0  = req0_valid & (~r_rsp0_valid | rsp0_ready);
    w_elig1  = req1_valid & (~r_rsp1_valid | rsp1_ready);
    w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
    w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);
  end

  // Route the granted requester's operands to the ALU; idle drives zeros
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (w_grant0) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (w_grant1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  // Round-robin pointer: follows the winner, holds on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

  // Response slot 0: refill on accept (even while draining), else clear on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_zero   <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= alu_result;
      r_rsp0_zero   <= alu_zero;
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  // Response slot 1: same policy as slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_zero   <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= alu_result;
      r_rsp1_zero   <= alu_zero;
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  // Saturating count of accepted operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if ((w_grant0 | w_grant1) && (r_op_count != CNT_MAX)) begin
      r_op_count <= r_op_count + CNTW'(1);
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_zero   = r_rsp0_zero;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_zero   = r_rsp1_zero;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model (per-requester slot arrays, round-robin pointer,
// saturating counter). CNTW is shrunk to 4 so saturation is reachable.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 4;
  localparam int unsigned CNTW  = 4;
  localparam int          CMAX  = (1 << CNTW) - 1;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;
  logic [CNTW-1:0]  op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int               m_last;
  logic             m_vld  [2];
  logic [WIDTH-1:0] m_res  [2];
  logic             m_zero [2];
  int               m_cnt;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A
  function automatic logic [WIDTH-1:0] ref_alu(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [OPW-1:0] op);
    case (op)
      OPW'(0): return a + b;
      OPW'(1): return a - b;
      OPW'(2): return a & b;
      OPW'(3): return a | b;
      OPW'(4): return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == '0);
  end

  function automatic logic [WIDTH-1:0] rnd_opnd();
    if ($urandom_range(0, 1) == 0) return WIDTH'($urandom_range(0, 3));
    return WIDTH'($urandom);
  endfunction

  // which requester the rules say should win this cycle (-1 = none)
  function automatic int exp_grant();
    bit e0, e1;
    e0 = req0_valid && (!m_vld[0] || rsp0_ready);
    e1 = req1_valid && (!m_vld[1] || rsp1_ready);
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_cnt  = 0;
    for (int n = 0; n < 2; n++) begin
      m_vld[n] = 1'b0; m_res[n] = '0; m_zero[n] = 1'b0;
    end
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  // advance one clock edge and update the model; returns at posedge + 1
  task automatic tick();
    int g;
    logic [WIDTH-1:0] r;
    bit rr[2];
    g = exp_grant();
    rr[0] = rsp0_ready; rr[1] = rsp1_ready;
    r = (g == 0) ? ref_alu(req0_a, req0_b, req0_op) : ref_alu(req1_a, req1_b, req1_op);
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (g == n) begin
        m_vld[n] = 1'b1; m_res[n] = r; m_zero[n] = (r == '0);
      end else if (m_vld[n] && rr[n]) begin
        m_vld[n] = 1'b0;
      end
    end
    if (g >= 0) begin
      m_last = g;
      if (m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    model_reset();
    #12;
    n_tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b%b exp 00", rsp0_valid, rsp1_valid); end
    n_tests++; if (rsp0_result !== '0 || rsp1_result !== '0) begin n_fail++; $display("FAIL reset_result got %0h/%0h exp 0/0", rsp0_result, rsp1_result); end
    n_tests++; if (rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b%b exp 00", rsp0_zero, rsp1_zero); end
    n_tests++; if (op_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", op_count); end
    @(negedge clk);
    rst_n = 1;
    tick();
    n_tests++; if (rsp0_valid !== 1'b0 || op_count !== '0 || alu_a !== '0) begin n_fail++; $display("FAIL reset_idle got v=%b cnt=%0d alu_a=%0h exp 0/0/0", rsp0_valid, op_count, alu_a); end
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready); end
    n_tests++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd0) begin n_fail++; $display("FAIL single_alu got %0h %0h %0h exp 5 3 0", alu_a, alu_b, alu_op); end
    tick();
    idle();
    n_tests++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd8 || rsp0_zero !== 1'b0) begin n_fail++; $display("FAIL single_rsp got v=%b r=%0d z=%b exp 1 8 0", rsp0_valid, rsp0_result, rsp0_zero); end
    n_tests++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", op_count); end
    tick();
  endtask

  task automatic test_alternate();
    logic [WIDTH-1:0] er;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_a = rnd_opnd(); req0_b = rnd_opnd(); req0_op = OPW'($urandom_range(0, 5));
      req1_valid = 1; req1_a = rnd_opnd(); req1_b = rnd_opnd(); req1_op = OPW'($urandom_range(0, 5));
      #1;
      n_tests++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_grant[%0d] got %b%b exp %b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1); end
      er = (i % 2 == 0) ? ref_alu(req0_a, req0_b, req0_op) : ref_alu(req1_a, req1_b, req1_op);
      tick();
      n_tests++; if (((i % 2 == 0) ? rsp0_result : rsp1_result) !== er) begin n_fail++; $display("FAIL alt_result[%0d] got %0h exp %0h", i, (i % 2 == 0) ? rsp0_result : rsp1_result, er); end
    end
    idle();
    n_tests++; if (op_count !== 4'd4) begin n_fail++; $display("FAIL alt_count got %0d exp 4", op_count); end
    tick();
  endtask

  task automatic test_hol();
    logic [WIDTH-1:0] saved, er;
    apply_reset();
    req0_valid = 1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 1; rsp0_ready = 0;
    saved = 32'd99;
    #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      req0_a = 32'd7; req0_b = 32'd7; req0_op = 0;
      req1_valid = 1; req1_a = rnd_opnd(); req1_b = rnd_opnd(); req1_op = OPW'($urandom_range(0, 5));
      rsp1_ready = 1;
      #1;
      n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL hol_grant[%0d] got %b%b exp 01", i, req0_ready, req1_ready); end
      er = ref_alu(req1_a, req1_b, req1_op);
      tick();
      n_tests++; if (rsp0_valid !== 1'b1 || rsp0_result !== saved || rsp1_result !== er) begin n_fail++; $display("FAIL hol_hold[%0d] got v0=%b r0=%0h r1=%0h exp 1 %0h %0h", i, rsp0_valid, rsp0_result, rsp1_result, saved, er); end
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
    #1;
    tick();
    n_tests++; if (rsp0_valid !== 1'b0 || rsp0_result !== saved) begin n_fail++; $display("FAIL hol_drain got v=%b r=%0h exp 0 %0h", rsp0_valid, rsp0_result, saved); end
    idle();
    tick();
  endtask

  task automatic test_overwrite();
    logic [WIDTH-1:0] er;
    apply_reset();
    req1_valid = 1; req1_a = 32'd40; req1_b = 32'd2; req1_op = 0; rsp1_ready = 0;
    #1;
    tick();
    req1_a = 32'h0F0; req1_b = 32'h00F; req1_op = 3; rsp1_ready = 1;
    er = 32'h0FF;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL ovw_ready got %b exp 1", req1_ready); end
    tick();
    req1_valid = 0;
    n_tests++; if (rsp1_valid !== 1'b1 || rsp1_result !== er) begin n_fail++; $display("FAIL ovw_rsp got v=%b r=%0h exp 1 %0h", rsp1_valid, rsp1_result, er); end
    tick();
    n_tests++; if (rsp1_valid !== 1'b0 || rsp1_result !== er) begin n_fail++; $display("FAIL ovw_drain got v=%b r=%0h exp 0 %0h", rsp1_valid, rsp1_result, er); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 0;
    req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    n_tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || op_count !== '0) begin n_fail++; $display("FAIL areset got v=%b%b cnt=%0d exp 00 0", rsp0_valid, rsp1_valid, op_count); end
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1;
    tick();
    req0_valid = 1; req1_valid = 1;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL areset_first got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < CMAX; i++) begin
      req0_valid = 1; req0_a = rnd_opnd(); req0_b = rnd_opnd(); req0_op = OPW'($urandom_range(0, 5));
      #1;
      tick();
    end
    n_tests++; if (op_count !== CNTW'(CMAX)) begin n_fail++; $display("FAIL sat_full got %0d exp %0d", op_count, CMAX); end
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready got %b exp 1", req0_ready); end
    tick();
    idle();
    n_tests++; if (op_count !== CNTW'(CMAX)) begin n_fail++; $display("FAIL sat_hold got %0d exp %0d", op_count, CMAX); end
    tick();
  endtask

  task automatic test_random();
    int g;
    bit hold0, hold1;
    apply_reset();
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_a = rnd_opnd(); req0_b = rnd_opnd(); req0_op = OPW'($urandom_range(0, 6));
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_a = rnd_opnd(); req1_b = rnd_opnd(); req1_op = OPW'($urandom_range(0, 6));
      end
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      #1;
      g = exp_grant();
      n_tests++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin n_fail++; $display("FAIL rnd_grant[%0d] got %b%b exp grant %0d", i, req0_ready, req1_ready, g); end
      n_tests++;
      if (g == 0 ? (alu_a !== req0_a || alu_b !== req0_b || alu_op !== req0_op) :
          g == 1 ? (alu_a !== req1_a || alu_b !== req1_b || alu_op !== req1_op) :
                   (alu_a !== '0 || alu_b !== '0 || alu_op !== '0)) begin
        n_fail++; $display("FAIL rnd_alu[%0d] got %0h %0h %0h for grant %0d", i, alu_a, alu_b, alu_op, g);
      end
      hold0 = req0_valid && (g != 0);
      hold1 = req1_valid && (g != 1);
      tick();
      n_tests++; if (rsp0_valid !== m_vld[0] || rsp0_result !== m_res[0] || rsp0_zero !== m_zero[0]) begin n_fail++; $display("FAIL rnd_rsp0[%0d] got %b %0h %b exp %b %0h %b", i, rsp0_valid, rsp0_result, rsp0_zero, m_vld[0], m_res[0], m_zero[0]); end
      n_tests++; if (rsp1_valid !== m_vld[1] || rsp1_result !== m_res[1] || rsp1_zero !== m_zero[1]) begin n_fail++; $display("FAIL rnd_rsp1[%0d] got %b %0h %b exp %b %0h %b", i, rsp1_valid, rsp1_result, rsp1_zero, m_vld[1], m_res[1], m_zero[1]); end
      n_tests++; if (op_count !== CNTW'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, op_count, m_cnt); end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_hol();
    test_overwrite();
    test_async_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
